// File: rtl/step_sched_defs.sv
// Shared state encodings for the step scheduler.
// The RTL and the bench both import this package.
package step_sched_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        RUN   = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/step_ctr.sv
// Shared 3-bit step counter: synchronous clear, count enable, 7->0 wrap.
// Clear takes priority over enable.
module step_ctr (
    input  logic clk,
    input  logic Re,
    input  logic en,
    input  logic clr,
    output logic z2,
    output logic z1,
    output logic z0
);

    logic [2:0] q;

    always_ff @(posedge clk or posedge Re) begin
        if (Re) begin
            q <= 3'd0;
        end else if (clr) begin
            q <= 3'd0;
        end else if (en) begin
            q <= q + 3'd1;
        end
    end

    assign z2 = q[2];
    assign z1 = q[1];
    assign z0 = q[0];

endmodule

// File: rtl/step_sched.sv
// Two-requester step scheduler: arbitrates req0/req1, then advances
// the shared step counter n times for the granted requester.
module step_sched
    import step_sched_defs::*;
#(
    parameter bit RR           = 1'b1,
    parameter bit CLR_ON_GRANT = 1'b1
) (
    input  logic       clk,
    input  logic       Re,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] n0,
    input  logic [2:0] n1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       busy,
    output logic       z2,
    output logic       z1,
    output logic       z0
);

    state_t     st, st_nx;
    logic       own, own_nx;
    logic       last, last_nx;
    logic [2:0] rem, rem_nx;
    logic       pick, req_own;
    logic       ctr_en, ctr_clr;

    always_ff @(posedge clk or posedge Re) begin
        if (Re) begin
            st   <= IDLE;
            own  <= 1'b0;
            last <= 1'b1;
            rem  <= 3'd0;
        end else begin
            st   <= st_nx;
            own  <= own_nx;
            last <= last_nx;
            rem  <= rem_nx;
        end
    end

    assign req_own = own ? req1 : req0;

    // On a tie, round-robin favours whoever was not served last
    always_comb begin
        pick = 1'b0;
        if (RR) begin
            pick = (req0 && req1) ? ~last : req1;
        end else begin
            pick = ~req0;
        end
    end

    always_comb begin
        st_nx   = st;
        own_nx  = own;
        last_nx = last;
        rem_nx  = rem;
        ctr_en  = 1'b0;
        ctr_clr = 1'b0;
        unique case (st)
            IDLE: begin
                if (req0 || req1) begin
                    st_nx   = GRANT;
                    own_nx  = pick;
                    rem_nx  = pick ? n1 : n0;
                    ctr_clr = CLR_ON_GRANT;
                end
            end
            GRANT: begin
                if (!req_own) begin
                    st_nx   = IDLE;
                    last_nx = own;
                end else if (rem == 3'd0) begin
                    st_nx = DONE;
                end else begin
                    st_nx = RUN;
                end
            end
            RUN: begin
                if (!req_own) begin
                    st_nx   = IDLE;
                    last_nx = own;
                end else begin
                    ctr_en = 1'b1;
                    rem_nx = rem - 3'd1;
                    if (rem == 3'd1) begin
                        st_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (!req_own) begin
                    st_nx   = IDLE;
                    last_nx = own;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    assign busy  = (st != IDLE);
    assign gnt0  = busy && !own;
    assign gnt1  = busy && own;
    assign done0 = (st == DONE) && !own;
    assign done1 = (st == DONE) && own;

    step_ctr u_ctr (
        .clk (clk),
        .Re  (Re),
        .en  (ctr_en),
        .clr (ctr_clr),
        .z2  (z2),
        .z1  (z1),
        .z0  (z0)
    );

endmodule

// File: tb/tb_step_sched.sv
// Directed bench for step_sched: round-robin, fixed-priority and
// no-clear-on-grant variants driven from one shared stimulus.
module tb_step_sched;
    import step_sched_defs::*;

    logic       clk = 1'b0;
    logic       Re = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [2:0] n0 = 3'd0;
    logic [2:0] n1 = 3'd0;

    logic [2:0] gnt0, gnt1, done0, done1, busy, z2, z1, z0;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // 0: round-robin, clear on grant
    step_sched #(.RR(1'b1), .CLR_ON_GRANT(1'b1)) u_rr (
        .clk(clk), .Re(Re), .req0(req0), .req1(req1), .n0(n0), .n1(n1),
        .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
        .busy(busy[0]), .z2(z2[0]), .z1(z1[0]), .z0(z0[0])
    );

    // 1: fixed priority, clear on grant
    step_sched #(.RR(1'b0), .CLR_ON_GRANT(1'b1)) u_fp (
        .clk(clk), .Re(Re), .req0(req0), .req1(req1), .n0(n0), .n1(n1),
        .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
        .busy(busy[1]), .z2(z2[1]), .z1(z1[1]), .z0(z0[1])
    );

    // 2: round-robin, counter kept across grants
    step_sched #(.RR(1'b1), .CLR_ON_GRANT(1'b0)) u_nc (
        .clk(clk), .Re(Re), .req0(req0), .req1(req1), .n0(n0), .n1(n1),
        .gnt0(gnt0[2]), .gnt1(gnt1[2]), .done0(done0[2]), .done1(done1[2]),
        .busy(busy[2]), .z2(z2[2]), .z1(z1[2]), .z0(z0[2])
    );

    // {busy, gnt1, gnt0, done1, done0, z2, z1, z0}
    function automatic logic [7:0] obs(input int i);
        return {busy[i], gnt1[i], gnt0[i], done1[i], done0[i],
                z2[i], z1[i], z0[i]};
    endfunction

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Re   = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        n0   = 3'd0;
        n1   = 3'd0;
        tick();
        Re = 1'b0;
    endtask

    initial begin
        // basic: req0, n0=3
        do_reset();
        check("rst_rr", obs(0), 8'b0000_0000);
        check("rst_st", {6'd0, u_rr.st}, {6'd0, IDLE});
        req0 = 1'b1;
        n0   = 3'd3;
        tick();
        check("a_e1", obs(0), 8'b1010_0000);
        n0 = 3'd7;
        tick();
        check("a_e2", obs(0), 8'b1010_0000);
        check("a_st", {6'd0, u_rr.st}, {6'd0, RUN});
        tick();
        check("a_e3", obs(0), 8'b1010_0001);
        tick();
        check("a_e4", obs(0), 8'b1010_0010);
        tick();
        check("a_e5", obs(0), 8'b1010_1011);
        tick();
        check("a_hold", obs(0), 8'b1010_1011);
        req0 = 1'b0;
        tick();
        check("a_idle", obs(0), 8'b0000_0011);

        // simultaneous requests; rr vs fixed priority on the rematch
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        n0   = 3'd1;
        n1   = 3'd1;
        tick();
        check("b_rr_e1", obs(0), 8'b1010_0000);
        check("b_fp_e1", obs(1), 8'b1010_0000);
        tick();
        check("b_rr_e2", obs(0), 8'b1010_0000);
        tick();
        check("b_rr_e3", obs(0), 8'b1010_1001);
        req0 = 1'b0;
        tick();
        check("b_rr_e4", obs(0), 8'b0000_0001);
        req0 = 1'b1;
        tick();
        check("b_rr_e5", obs(0), 8'b1100_0000);
        check("b_fp_e5", obs(1), 8'b1010_0000);

        // no clear on grant: park counter at 110, then wrap
        do_reset();
        req0 = 1'b1;
        n0   = 3'd6;
        repeat (8) tick();
        check("c_done0", obs(2), 8'b1010_1110);
        req0 = 1'b0;
        tick();
        check("c_idle", obs(2), 8'b0000_0110);
        req1 = 1'b1;
        n1   = 3'd3;
        tick();
        check("c_gnt", obs(2), 8'b1100_0110);
        tick();
        check("c_run", obs(2), 8'b1100_0110);
        tick();
        check("c_111", obs(2), 8'b1100_0111);
        tick();
        check("c_wrap", obs(2), 8'b1100_0000);
        tick();
        check("c_done1", obs(2), 8'b1101_0001);
        req1 = 1'b0;
        tick();

        // zero-length grant
        do_reset();
        req0 = 1'b1;
        n0   = 3'd0;
        tick();
        check("d_gnt", obs(0), 8'b1010_0000);
        tick();
        check("d_done", obs(0), 8'b1010_1000);
        check("d_nc", obs(2), 8'b1010_1000);
        req0 = 1'b0;
        tick();
        check("d_idle", obs(0), 8'b0000_0000);

        // abort after two RUN cycles, pending req1 follows
        do_reset();
        req0 = 1'b1;
        n0   = 3'd7;
        req1 = 1'b1;
        n1   = 3'd2;
        tick();
        check("e_e1", obs(0), 8'b1010_0000);
        tick();
        check("e_e2", obs(0), 8'b1010_0000);
        tick();
        check("e_e3", obs(0), 8'b1010_0001);
        tick();
        check("e_e4", obs(0), 8'b1010_0010);
        req0 = 1'b0;
        tick();
        check("e_abort", obs(0), 8'b0000_0010);
        tick();
        check("e_gnt1", obs(0), 8'b1100_0000);
        req1 = 1'b0;
        tick();

        // asynchronous reset mid-RUN, then a fresh request
        do_reset();
        req0 = 1'b1;
        n0   = 3'd5;
        repeat (4) tick();
        check("f_run", obs(0), 8'b1010_0010);
        #1;
        Re = 1'b1;
        #1;
        check("f_async_rr", obs(0), 8'b0000_0000);
        check("f_async_fp", obs(1), 8'b0000_0000);
        check("f_async_nc", obs(2), 8'b0000_0000);
        check("f_async_st", {6'd0, u_rr.st}, {6'd0, IDLE});
        #1;
        Re   = 1'b0;
        req0 = 1'b0;
        n0   = 3'd2;
        tick();
        check("f_idle", obs(0), 8'b0000_0000);
        req0 = 1'b1;
        tick();
        check("f_gnt", obs(0), 8'b1010_0000);
        tick();
        tick();
        check("f_run2", obs(0), 8'b1010_0001);
        tick();
        check("f_done", obs(0), 8'b1010_1010);
        req0 = 1'b0;
        tick();
        check("f_end", obs(0), 8'b0000_0010);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
